// File: rtl/core_pkg.sv
// Shared types and constants for the RV32 multi-cycle sequencer.
// State encoding, bus access mode codes and default vectors.
package core_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    localparam logic [2:0] MODE_LB     = 3'b000;
    localparam logic [2:0] MODE_LH     = 3'b001;
    localparam logic [2:0] MODE_LW     = 3'b010;
    localparam logic [2:0] MODE_LBU    = 3'b100;
    localparam logic [2:0] MODE_LHU    = 3'b101;
    localparam logic [2:0] MODE_IFETCH = 3'b111;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/load_ext.sv
// Load data extension by access mode.
// Bus data arrives right-aligned; unknown modes pass the word through.
module load_ext
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      mode,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] ext
);

    // sign or zero extend the low byte/half according to funct3
    always_comb begin
        ext = data;
        unique case (mode)
            MODE_LB:  ext = {{(XLEN-8){data[7]}}, data[7:0]};
            MODE_LH:  ext = {{(XLEN-16){data[15]}}, data[15:0]};
            MODE_LBU: ext = {{(XLEN-8){1'b0}}, data[7:0]};
            MODE_LHU: ext = {{(XLEN-16){1'b0}}, data[15:0]};
            default:  ext = data;
        endcase
    end

endmodule

// File: rtl/core_seq.sv
// Multi-cycle sequencer: PC, fetch/decode/execute/memory/write-back FSM,
// bus handshake, load extension, trap entry, mret and retire counter.
module core_seq
    import core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [XLEN-1:0] TRAP_VEC  = DEF_TRAP_VEC,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intr,
    output logic             mem_req,
    output logic             mem_wen,
    output logic [2:0]       mem_mode,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_dat_o,
    input  logic [XLEN-1:0]  mem_dat_i,
    input  logic             mem_ready,
    output logic [XLEN-1:0]  inst,
    output logic [XLEN-1:0]  pc,
    input  logic             dec_mem_load,
    input  logic             dec_mem_wr,
    input  logic             dec_reg_wr,
    input  logic             dec_mret,
    input  logic [2:0]       dec_mem_opt,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  next_pc,
    input  logic [XLEN-1:0]  store_data,
    output logic             reg_wen,
    output logic [XLEN-1:0]  rwdata,
    output logic [CNT_W-1:0] retired
);

    state_t          state, state_nx;
    logic [XLEN-1:0] alu_q, store_q, load_q, mepc, ext;
    logic            mie;

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .mode (dec_mem_opt),
        .data (mem_dat_i),
        .ext  (ext)
    );

    // next state; an mret in write-back suppresses the trap that cycle
    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:     if (mem_ready) state_nx = S_DECODE;
            S_DECODE:    state_nx = S_EXECUTE;
            S_EXECUTE:   state_nx = (dec_mem_load || dec_mem_wr)
                                    ? S_MEMORY : S_WRITEBACK;
            S_MEMORY:    if (mem_ready) state_nx = S_WRITEBACK;
            S_WRITEBACK: state_nx = (intr && mie && !dec_mret)
                                    ? S_TRAP : S_FETCH;
            S_TRAP:      state_nx = S_FETCH;
            default:     state_nx = S_FETCH;
        endcase
    end

    // bus and register-file outputs decoded from the current state
    always_comb begin
        mem_req   = 1'b0;
        mem_wen   = 1'b0;
        mem_mode  = MODE_IFETCH;
        mem_addr  = pc;
        mem_dat_o = store_q;
        reg_wen   = 1'b0;
        rwdata    = dec_mem_load ? load_q : alu_q;
        if (!rst) begin
            unique case (state)
                S_FETCH: mem_req = 1'b1;
                S_MEMORY: begin
                    mem_req  = 1'b1;
                    mem_wen  = dec_mem_wr;
                    mem_mode = dec_mem_opt;
                    mem_addr = alu_q;
                end
                S_WRITEBACK: reg_wen = dec_mem_load || dec_reg_wr;
                default: ;
            endcase
        end
    end

    // state register and per-stage datapath latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_VEC;
            mie     <= 1'b0;
            mepc    <= '0;
            retired <= '0;
            inst    <= '0;
            alu_q   <= '0;
            store_q <= '0;
            load_q  <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_FETCH: if (mem_ready) inst <= mem_dat_i;
                S_EXECUTE: begin
                    alu_q   <= alu_result;
                    store_q <= store_data;
                end
                S_MEMORY: if (mem_ready && dec_mem_load) load_q <= ext;
                S_WRITEBACK: begin
                    retired <= retired + CNT_W'(1);
                    if (dec_mret) begin
                        pc  <= mepc;
                        mie <= 1'b1;
                    end else begin
                        pc <= next_pc;
                    end
                end
                S_TRAP: begin
                    mepc <= pc;
                    pc   <= TRAP_VEC;
                    mie  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Directed self-checking bench for core_seq.
// Bench plays bus, decoder, ALU and PC generator.
module tb_core_seq;

    logic        clk = 1'b0;
    logic        rst, intr, mem_req, mem_wen, mem_ready;
    logic [2:0]  mem_mode, dec_mem_opt;
    logic [31:0] mem_addr, mem_dat_o, mem_dat_i, inst, pc;
    logic        dec_mem_load, dec_mem_wr, dec_reg_wr, dec_mret;
    logic [31:0] alu_result, next_pc, store_data, rwdata, retired;
    logic        reg_wen;

    int n_chk = 0;
    int n_fail = 0;
    int exp_ret = 0;

    int          lat, wn, wc, mn;
    logic        mok, mwe;
    logic [31:0] wd, fa, ma, mdo;

    core_seq dut (
        .clk(clk), .rst(rst), .intr(intr),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_mode(mem_mode),
        .mem_addr(mem_addr), .mem_dat_o(mem_dat_o),
        .mem_dat_i(mem_dat_i), .mem_ready(mem_ready),
        .inst(inst), .pc(pc),
        .dec_mem_load(dec_mem_load), .dec_mem_wr(dec_mem_wr),
        .dec_reg_wr(dec_reg_wr), .dec_mret(dec_mret),
        .dec_mem_opt(dec_mem_opt), .alu_result(alu_result),
        .next_pc(next_pc), .store_data(store_data),
        .reg_wen(reg_wen), .rwdata(rwdata), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one instruction, starting in its FETCH cycle, ending at next fetch
    task automatic run_instr(
        input  logic ld, wr, rw, mr, irq,
        input  logic [2:0] opt,
        input  logic [31:0] alu, npc, sd, fdat, mdat,
        input  int fw, mw,
        output int lat_o, output int wen_n, output int wen_cyc,
        output logic [31:0] wdat, output logic [31:0] faddr,
        output int mem_n, output logic mem_ok, output logic mem_we,
        output logic [31:0] maddr, output logic [31:0] mdat_o);
        int c, w;
        logic fetched;
        logic [31:0] a0, d0;
        logic e0;
        dec_mem_load = ld; dec_mem_wr = wr; dec_reg_wr = rw;
        dec_mret = mr; dec_mem_opt = opt; intr = irq;
        alu_result = alu; next_pc = npc; store_data = sd;
        faddr = mem_addr;
        c = 0; w = 0; fetched = 0; lat_o = 0;
        wen_n = 0; wen_cyc = 0; wdat = 0;
        mem_n = 0; mem_ok = 1; mem_we = 0; maddr = 0; mdat_o = 0;
        a0 = 0; d0 = 0; e0 = 0;
        while (c < 60) begin
            c++;
            mem_ready = 0;
            mem_dat_i = 0;
            if (mem_req && !fetched) begin
                mem_dat_i = fdat;
                if (w == fw) begin
                    mem_ready = 1; fetched = 1; w = 0;
                end else w++;
            end else if (mem_req && mem_mode == 3'b111) begin
                lat_o = c - 1;
                break;
            end else if (mem_req) begin
                if (mem_n == 0) begin
                    a0 = mem_addr; d0 = mem_dat_o; e0 = mem_wen;
                    maddr = mem_addr; mdat_o = mem_dat_o; mem_we = mem_wen;
                end else if (mem_addr !== a0 || mem_dat_o !== d0 ||
                             mem_wen !== e0 || mem_mode !== opt) begin
                    mem_ok = 0;
                end
                mem_n++;
                mem_dat_i = mdat;
                if (w == mw) begin
                    mem_ready = 1; w = 0;
                end else w++;
            end
            if (reg_wen) begin
                wen_n++; wen_cyc = c; wdat = rwdata;
            end
            step();
        end
        mem_ready = 0;
        intr = 0;
        exp_ret++;
    endtask

    initial begin
        rst = 1; intr = 0; mem_ready = 0; mem_dat_i = 0;
        dec_mem_load = 0; dec_mem_wr = 0; dec_reg_wr = 0; dec_mret = 0;
        dec_mem_opt = 0; alu_result = 0; next_pc = 0; store_data = 0;
        repeat (2) step();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ret", retired, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_regwen", 32'(reg_wen), 32'd0);
        chk("rst_rwdata", rwdata, 32'd0);
        rst = 0;
        #1;

        // ADDI x1, x0, 5
        run_instr(0, 0, 1, 0, 0, 3'b000, 32'd5, 32'h4, 0, 32'h0050_0093,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("addi_faddr", fa, 32'h0);
        chk("addi_lat", lat, 4);
        chk("addi_wen_n", wn, 1);
        chk("addi_wen_cyc", wc, 4);
        chk("addi_wdat", wd, 32'd5);
        chk("addi_ret", retired, 32'(exp_ret));
        chk("addi_pc", pc, 32'h4);
        chk("addi_inst", inst, 32'h0050_0093);

        // LB with one fetch wait state
        run_instr(1, 0, 1, 0, 0, 3'b000, 32'h200, 32'h8, 0, 32'h2000_0083,
                  32'h80, 1, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("lb_faddr", fa, 32'h4);
        chk("lb_lat", lat, 6);
        chk("lb_maddr", ma, 32'h200);
        chk("lb_wdat", wd, 32'hFFFF_FF80);
        chk("lb_wen_n", wn, 1);

        run_instr(1, 0, 1, 0, 0, 3'b100, 32'h201, 32'hC, 0, 32'h2010_4083,
                  32'h80, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("lbu_lat", lat, 5);
        chk("lbu_wdat", wd, 32'h0000_0080);

        run_instr(1, 0, 1, 0, 0, 3'b001, 32'h204, 32'h10, 0, 32'h2040_1083,
                  32'h8001, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("lh_wdat", wd, 32'hFFFF_8001);

        run_instr(1, 0, 1, 0, 0, 3'b101, 32'h206, 32'h14, 0, 32'h2060_5083,
                  32'h8001, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("lhu_wdat", wd, 32'h0000_8001);

        run_instr(1, 0, 1, 0, 0, 3'b010, 32'h208, 32'h18, 0, 32'h2080_2083,
                  32'hDEAD_BEEF, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma,
                  mdo);
        chk("lw_wdat", wd, 32'hDEAD_BEEF);
        chk("lw_faddr", fa, 32'h14);

        // SW with three memory wait states
        run_instr(0, 1, 0, 0, 0, 3'b010, 32'h300, 32'h1C, 32'hCAFE_F00D,
                  32'h3010_2023, 0, 0, 3, lat, wn, wc, wd, fa, mn, mok, mwe,
                  ma, mdo);
        chk("sw_lat", lat, 8);
        chk("sw_mem_n", mn, 4);
        chk("sw_stable", 32'(mok), 32'd1);
        chk("sw_wen", 32'(mwe), 32'd1);
        chk("sw_addr", ma, 32'h300);
        chk("sw_data", mdo, 32'hCAFE_F00D);
        chk("sw_regwen", wn, 0);
        chk("sw_ret", retired, 32'(exp_ret));

        // mret with intr high: restore to mepc=0, no trap
        run_instr(0, 0, 0, 1, 1, 3'b000, 0, 32'h20, 0, 32'h3020_0073,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("mret0_lat", lat, 4);
        chk("mret0_pc", pc, 32'h0);

        // interrupt taken with mie=1
        run_instr(0, 0, 1, 0, 1, 3'b000, 32'd1, 32'h40, 0, 32'h0010_0093,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("trap_lat", lat, 5);
        chk("trap_pc", pc, 32'h100);
        chk("trap_ret", retired, 32'(exp_ret));

        // mie cleared by the trap: intr ignored
        run_instr(0, 0, 1, 0, 1, 3'b000, 32'd2, 32'h104, 0, 32'h0020_0093,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("mie0_lat", lat, 4);
        chk("mie0_pc", pc, 32'h104);

        // mret to mepc=0x40 with simultaneous intr
        run_instr(0, 0, 0, 1, 1, 3'b000, 0, 32'h108, 0, 32'h3020_0073,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("mret_faddr", fa, 32'h104);
        chk("mret_lat", lat, 4);
        chk("mret_pc", pc, 32'h40);

        // mie now 1: trap again, mepc=0x44
        run_instr(0, 0, 1, 0, 1, 3'b000, 32'd3, 32'h44, 0, 32'h0030_0093,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("trap2_faddr", fa, 32'h40);
        chk("trap2_lat", lat, 5);
        chk("trap2_pc", pc, 32'h100);

        run_instr(0, 0, 0, 1, 0, 3'b000, 0, 32'h104, 0, 32'h3020_0073,
                  0, 0, 0, lat, wn, wc, wd, fa, mn, mok, mwe, ma, mdo);
        chk("mret2_pc", pc, 32'h44);

        // reset during a memory wait
        dec_mem_load = 1; dec_mem_wr = 0; dec_reg_wr = 1; dec_mret = 0;
        dec_mem_opt = 3'b010; alu_result = 32'h500;
        mem_ready = 1; mem_dat_i = 32'h5000_2083;
        step();
        mem_ready = 0;
        step();
        step();
        chk("mrst_req_pre", 32'(mem_req), 32'd1);
        chk("mrst_addr_pre", mem_addr, 32'h500);
        step();
        rst = 1;
        step();
        chk("mrst_req", 32'(mem_req), 32'd0);
        chk("mrst_pc", pc, 32'h0);
        chk("mrst_ret", retired, 32'd0);
        chk("mrst_regwen", 32'(reg_wen), 32'd0);
        rst = 0;
        #1;
        chk("mrst_fetch_req", 32'(mem_req), 32'd1);
        chk("mrst_fetch_addr", mem_addr, 32'h0);
        chk("mrst_fetch_mode", 32'(mem_mode), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/core_seq.md
# core_seq

Parametrised multi-cycle sequencer for the RV32 core. It owns the PC, the fetch/decode/execute/memory/write-back state machine, the memory request handshake with wait states, and load sign/zero extension. It also handles interrupt trap entry and `mret` return, and counts retired instructions. It sits between the bus port and the existing decode, ALU and GPR blocks, which stay combinational/external.

## Interface
Parameters:
- `XLEN`, 32, data/address width.
- `RESET_VEC`, 32'h0000_0000, PC loaded on reset.
- `TRAP_VEC`, 32'h0000_0100, PC loaded on interrupt entry.
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk` in 1: clock; single clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `intr` in 1: level interrupt request.
- `mem_req` out 1: bus request.
- `mem_wen` out 1: bus write enable.
- `mem_mode` out 3: access size (funct3 encoding; 3'b111 = instruction word).
- `mem_addr` out XLEN: bus address.
- `mem_dat_o` out XLEN: bus write data.
- `mem_dat_i` in XLEN: bus read data, right-aligned.
- `mem_ready` in 1: bus completion.
- `inst` out XLEN: latched instruction, to decode.
- `pc` out XLEN: current PC.
- `dec_mem_load`, `dec_mem_wr`, `dec_reg_wr`, `dec_mret` in 1 each: decoded controls.
- `dec_mem_opt` in 3: load/store funct3.
- `alu_result` in XLEN: ALU output.
- `next_pc` in XLEN: PC generator output (branch/jump resolved).
- `store_data` in XLEN: rs2 value.
- `reg_wen` out 1: GPR write enable.
- `rwdata` out XLEN: GPR write data.
- `retired` out CNT_W: retired-instruction count.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: `mem_req`=1, `mem_wen`=0, `mem_mode`=3'b111, `mem_addr`=`pc`. The block stays in FETCH until `mem_ready`=1; in that cycle it latches `inst`<=`mem_dat_i` and moves to DECODE.
- DECODE: one cycle for operand settling. Next state is EXECUTE.
- EXECUTE: the block registers `alu_result` and `store_data`. If `dec_mem_load` or `dec_mem_wr`, next state is MEMORY; otherwise WRITEBACK.
- MEMORY:
  - Drives `mem_req`=1, `mem_addr`=registered result, `mem_mode`=`dec_mem_opt`, `mem_wen`=`dec_mem_wr`, `mem_dat_o`=store data.
  - Holds all of these until `mem_ready`, then moves to WRITEBACK.
  - On a load, it latches extended data:
    - 000 sign-extends bit 7.
    - 001 sign-extends bit 15.
    - 100 and 101 zero-extend.
    - 010 passes the word through.
- WRITEBACK:
  - `reg_wen` pulses for one cycle if `dec_mem_load` or `dec_reg_wr`. `rwdata` is the load data or the ALU result, with load taking priority.
  - `retired` increments, wrapping modulo 2^CNT_W.
  - PC update: if `dec_mret`, `pc`<=`mepc` and `mie`<=1; otherwise `pc`<=`next_pc`.
  - If `intr`=1 and `mie`=1 (sampled this cycle), next state is TRAP; otherwise FETCH.
- TRAP: `mepc`<=PC already updated for the retired instruction, `pc`<=TRAP_VEC, `mie`<=0. Next state is FETCH. No instruction retires in TRAP.
- `mret` together with `intr` in the same WRITEBACK: the `mret` restore happens first, the new `mie`=1 is not yet visible, and no trap is taken that cycle.

## Timing
- Reset (`rst`=1 at a clock edge): state=FETCH, `pc`=RESET_VEC, `mie`=0, `mepc`=0, `retired`=0, `inst`=0, `reg_wen`=0, `rwdata`=0.
- While `rst` is high, `mem_req`=0 and `mem_wen`=0.
- Reset mid-access abandons the bus request with no write-back.
- Zero-wait latency: ALU instruction 4 cycles; load/store 5 cycles. Each wait cycle on `mem_ready` adds 1.
- Bus outputs are stable while `mem_req`=1 and `mem_ready`=0.
- `mem_req` drops in the cycle after `mem_ready`.

## Structure
- Shared package `core_pkg`: state enum, `mem_mode` codes (MODE_LB/LH/LW/LBU/LHU/IFETCH), default vectors.
- Sub-module `load_ext` (combinational extend by mode) is natural.

## Test plan
- Reset then `mem_ready` tied 1, `inst` = ADDI: `mem_addr`=0 on the first FETCH, `reg_wen` pulses on cycle 4, `retired`=1, `pc`=4.
- LB with `mem_dat_i`=32'h0000_0080: `rwdata`=32'hFFFF_FF80. LBU with the same data: 32'h0000_0080. LH with 32'h0000_8001: `rwdata`=32'hFFFF_8001.
- SW with `mem_ready` held low 3 cycles: `mem_addr`, `mem_dat_o` and `mem_wen`=1 stable for 4 cycles, `reg_wen` never asserted, latency 8 cycles.
- `mie`=1 via a prior `mret`, `intr`=1 during WRITEBACK at `next_pc`=32'h40: TRAP, `mepc`=32'h40, next fetch at 32'h100, `mie`=0.
- `mret` retired with `mepc`=32'h40: next fetch at 32'h40, `mie`=1; simultaneous `intr` is not taken that cycle.
- `rst` asserted during a MEMORY wait: next cycle `mem_req`=0, `pc`=RESET_VEC, `retired`=0.
